// File: rtl/ekf_fifo_pkg.sv
// Shared widths and status bundle for the EKF stream FIFOs.
// Monitors use fifo_status_t to snapshot FIFO occupancy and error state.
package ekf_fifo_pkg;

  localparam int STATUS_LVL_W = 16;

  function automatic int fifo_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [STATUS_LVL_W-1:0] level;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    overflow;
    logic                    underflow;
  } fifo_status_t;

endpackage

// File: rtl/stream_fifo_ptr.sv
// Wrapping pointer counter for stream_fifo.
// Wraps explicitly at DEPTH-1, so any DEPTH is supported.
module stream_fifo_ptr
  import ekf_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = fifo_w(DEPTH)
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    unique case (1'b1)
      clr: ptr_d = '0;
      inc: begin
        if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
        else ptr_d = ptr_q + PTR_W'(1);
      end
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/stream_fifo.sv
// FWFT valid/ready FIFO with level, thresholds and flush.
// Sticky error flags are built only with STREAM_FIFO_ERR_EN.
module stream_fifo
  import ekf_fifo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  localparam int LVL_W    = fifo_w(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LVL_W-1:0]  level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int PTR_W = fifo_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign s_ready = (level_q != LVL_W'(DEPTH));
  assign m_valid = (level_q != '0);
  assign push    = s_valid && s_ready && !flush;
  assign pop     = m_valid && m_ready && !flush;

  stream_fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .inc       (push),
    .clr       (flush),
    .ptr       (wr_ptr)
  );

  stream_fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .inc       (pop),
    .clr       (flush),
    .ptr       (rd_ptr)
  );

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      flush:         level_d = '0;
      push && !pop:  level_d = level_q + LVL_W'(1);
      pop  && !push: level_d = level_q - LVL_W'(1);
      default:       level_d = level_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = s_data;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

  assign level        = level_q;
  assign m_data       = mem_q[rd_ptr];
  assign almost_full  = (level_q >= LVL_W'(AFULL_TH));
  assign almost_empty = (level_q <= LVL_W'(AEMPTY_TH));

`ifdef STREAM_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error in the same cycle as err_clr must win.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (s_valid && !s_ready) ovf_d = 1'b1;
    if (m_ready && !m_valid) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed plus randomized bench for stream_fifo (DEPTH=6).
// Reference model: a queue of words plus an array image of memory.
module tb_stream_fifo;

  localparam int DW = 16;
  localparam int D  = 6;
  localparam int AF = 5;
  localparam int AE = 1;
`ifdef STREAM_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [2:0]    level;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  stream_fifo #(
    .DATA_W    (DW),
    .DEPTH     (D),
    .AFULL_TH  (AF),
    .AEMPTY_TH (AE)
  ) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] mem[D];
  int            wp, rp;
  bit            ovf, unf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < D; i++) mem[i] = '0;
    wp  = 0;
    rp  = 0;
    ovf = 0;
    unf = 0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_ready", 32'(s_ready), 32'(n != D));
    chk("m_valid", 32'(m_valid), 32'(n != 0));
    chk("level", 32'(level), 32'(n));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(ERR_EN & ovf));
    chk("underflow", 32'(underflow), 32'(ERR_EN & unf));
    chk("m_data", 32'(m_data), 32'(mem[rp]));
    if (n > 0) chk("head_order", 32'(m_data), 32'(q[0]));
  endtask

  task automatic drive(input bit sv, input logic [DW-1:0] sd,
                       input bit mr, input bit fl, input bit ec);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    err_clr = ec;
  endtask

  // Apply the rules to the inputs held across the next edge, then check.
  task automatic cycle();
    int  n;
    bit  acc_push, acc_pop;
    n        = q.size();
    acc_push = !flush && s_valid && (n < D);
    acc_pop  = !flush && m_ready && (n > 0);
    if (err_clr) begin
      ovf = 0;
      unf = 0;
    end
    if (s_valid && n == D) ovf = 1;
    if (m_ready && n == 0) unf = 1;
    if (flush) begin
      q.delete();
      wp = 0;
      rp = 0;
    end else begin
      if (acc_pop) begin
        void'(q.pop_front());
        rp = (rp + 1) % D;
      end
      if (acc_push) begin
        q.push_back(s_data);
        mem[wp] = s_data;
        wp = (wp + 1) % D;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    drive(0, '0, 0, 0, 0);
    model_reset();
    #2;
    check_all();
    #10;
    sys_rst_n = 1'b1;
    cycle();

    for (int i = 1; i <= 6; i++) begin
      drive(1, DW'(i), 0, 0, 0);
      cycle();
    end
    drive(1, 16'h0007, 0, 0, 0);
    cycle();

    for (int i = 0; i < 20; i++) begin
      drive(1, DW'(16'h0100 + i), 1, 0, 0);
      cycle();
    end
    drive(0, '0, 1, 0, 0);
    repeat (5) cycle();

    drive(1, 16'hBEEF, 0, 0, 0);
    cycle();
    chk("beef_head", 32'(m_data), 32'h0000BEEF);
    drive(0, '0, 1, 0, 0);
    cycle();
    drive(0, '0, 1, 0, 0);
    cycle();
    drive(0, '0, 0, 0, 1);
    cycle();
    drive(0, '0, 1, 0, 1);
    cycle();
    drive(0, '0, 0, 0, 1);
    cycle();

    for (int i = 0; i < 4; i++) begin
      drive(1, DW'(16'h0200 + i), 0, 0, 0);
      cycle();
    end
    drive(1, 16'hDEAD, 1, 1, 0);
    cycle();
    drive(1, 16'h0300, 0, 0, 0);
    cycle();
    chk("post_flush_head", 32'(m_data), 32'h00000300);
    drive(0, '0, 0, 0, 0);
    cycle();

    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 100; i++) begin
        drive(($urandom_range(0, 3) < ((ph % 2) ? 1 : 3)),
              DW'($urandom),
              ($urandom_range(0, 3) < ((ph % 2) ? 3 : 1)),
              ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 15) == 0));
        cycle();
      end
    end

    drive(0, '0, 0, 1, 1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, DW'(16'h0400 + i), (i > 1), 0, 0);
      cycle();
    end
    @(negedge clk);
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    sys_rst_n = 1'b1;
    drive(0, '0, 0, 0, 0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
